proc_run_ctrl: RTL and testbench
================================

Name: proc_run_ctrl

Overview:
Synthesizable run controller for the single-cycle RISC-V core, replacing the fixed-delay simulation harness.
- Streams a program image into instruction memory.
- Holds the core in reset for a parametrised number of cycles, then releases it.
- Counts executed cycles and stops on the halt instruction or on timeout.
- Reports status to the SoC or bench, and sits between a loader source (UART/DMA/bench) and the core plus its instruction memory.

Parameters:
DATA_W, 32, program word width
IMEM_DEPTH, 256, instruction memory depth in words (power of 2, >=2)
RST_CYCLES, 4, core reset hold length in cycles (>=1)
TIMEOUT_CYCLES, 1000, maximum RUN cycles before forced stop (>=1)
HALT_INSTR, 32'h0000_0073, instruction word that halts execution (ecall)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
load_valid  in  1  program word valid
load_ready  out  1  controller accepts a program word
load_data  in  DATA_W  program word
load_last  in  1  marks the final program word
start  in  1  single-cycle pulse: rerun the loaded program
core_inst  in  32  instruction fetched by the core this cycle
imem_we  out  1  instruction memory write enable
imem_waddr  out  $clog2(IMEM_DEPTH)  instruction memory word address
imem_wdata  out  DATA_W  instruction memory write data
core_rst  out  1  active-high reset to the core
core_en  out  1  core PC/register-file/data-memory write enable
done  out  1  run finished (halted or timed out)
halted  out  1  run ended on HALT_INSTR
timed_out  out  1  run ended on timeout
cycle_count  out  32  RUN cycles elapsed in the current or last run

Behaviour:
- States: IDLE, LOAD, RST_HOLD, RUN, HALTED, TIMEOUT.
- Reset (rst=0, async) values:
  - state=IDLE, core_rst=1, core_en=0, imem_we=0, imem_waddr=0, imem_wdata=0.
  - done=halted=timed_out=0, cycle_count=0, load_ready=0 until the first clock after rst deasserts.
  - Reset asserted mid-load or mid-run aborts immediately; memory contents already written are kept.
- load_ready=1 in IDLE, LOAD, HALTED and TIMEOUT; 0 in RST_HOLD and RUN.
- Load handshake is load_valid && load_ready.
  - Registered write: imem_we=1 with imem_waddr/imem_wdata valid on the cycle after the handshake, for one cycle per word.
  - The first accepted word after any non-LOAD state goes to address 0 and clears done, halted, timed_out and cycle_count.
  - Each further word uses address +1.
- LOAD -> RST_HOLD when the accepted word has load_last=1 or is written to address IMEM_DEPTH-1. No wrap: load_ready drops in the cycle after that acceptance.
- start in IDLE, HALTED or TIMEOUT -> RST_HOLD: clears status flags and cycle_count, program unchanged. start is ignored in LOAD, RST_HOLD and RUN.
- start and an accepted load word in the same cycle: load wins, start is dropped.
- RST_HOLD: core_rst=1, core_en=0 for exactly RST_CYCLES cycles, then RUN.
- RUN: core_rst=0, core_en=1, cycle_count increments every cycle (first RUN cycle shows 1 on the next edge).
- Exit from RUN:
  - core_inst==HALT_INSTR -> HALTED. core_en=0 from the next cycle, so the halt instruction causes no architectural writes beyond its own cycle. halted=done=1.
  - cycle_count reaching TIMEOUT_CYCLES -> TIMEOUT, core_en=0, timed_out=done=1.
  - Both in the same cycle: HALTED wins.
- HALTED/TIMEOUT: core_rst=0 and core_en=0, so architectural state is frozen and readable. Status flags and cycle_count hold until the next load or start.
- cycle_count saturates at 2^32-1; only reachable when TIMEOUT_CYCLES is that large.
- All outputs are registered.

Decomposition:
- Package proc_run_pkg holds:
  - run_state_e enum (6 states, 3-bit encoding)
  - localparam HALT_ECALL = 32'h0000_0073, used as the HALT_INSTR default
  - ST_* status bit index constants for a future CSR view
- One sub-module, run_timer: a loadable, saturating 32-bit counter with clear, enable and terminal-count compare. It serves both RST_CYCLES and TIMEOUT_CYCLES.

Test Plan:
- rst low for 2 cycles then high; stream 3 words 0x00200093, 0x00308113, 0x00000073 (last on the 3rd) -> imem writes at addresses 0,1,2 one cycle after each handshake; core_rst high 4 cycles; RUN; halt seen at cycle_count=3 -> halted=1, done=1, core_en=0.
- Program with no ecall, TIMEOUT_CYCLES=20 -> timed_out=1, done=1, cycle_count=20, halted=0.
- IMEM_DEPTH=4, stream 6 words with load_last never asserted -> exactly 4 writes (addresses 0..3), load_ready=0 after the 4th acceptance, RST_HOLD entered.
- After HALTED, pulse start -> flags clear, cycle_count=0, core_rst high RST_CYCLES cycles, same program reruns to the same cycle_count.
- Assert rst mid-RUN at cycle_count=7 -> asynchronously core_rst=1, core_en=0, cycle_count=0, state IDLE; a subsequent start reruns without reload.
- HALT_INSTR on core_inst in the same cycle cycle_count reaches TIMEOUT_CYCLES -> halted=1, timed_out=0.

Source files
------------

// File: rtl/proc_run_pkg.sv
// Shared types and constants for the processor run controller.
package proc_run_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_RST_HOLD = 3'd2,
        S_RUN      = 3'd3,
        S_HALTED   = 3'd4,
        S_TIMEOUT  = 3'd5
    } run_state_e;

    localparam logic [31:0] HALT_ECALL = 32'h0000_0073;

    // Bit positions of the status flags in a CSR-style status word.
    localparam int unsigned ST_DONE      = 0;
    localparam int unsigned ST_HALTED    = 1;
    localparam int unsigned ST_TIMED_OUT = 2;

endpackage

// File: rtl/run_timer.sv
// Saturating 32-bit counter with clear, load and enable. tc_o flags that the
// next increment lands on term_i, so callers can change state on that edge.
module run_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        load_i,
    input  logic [31:0] load_val_i,
    input  logic        en_i,
    input  logic [31:0] term_i,
    output logic [31:0] cnt_o,
    output logic        tc_o
);

    logic [31:0] cnt_q, cnt_d, inc;

    assign inc   = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
    assign tc_o  = (inc == term_i);
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)       cnt_d = 32'd0;
        else if (load_i) cnt_d = load_val_i;
        else if (en_i)   cnt_d = inc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 32'd0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/proc_run_ctrl.sv
// Run controller: streams a program into imem, holds the core in reset,
// runs it until ecall or timeout, and reports status.
module proc_run_ctrl import proc_run_pkg::*; #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned IMEM_DEPTH     = 256,
    parameter int unsigned RST_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter logic [31:0] HALT_INSTR     = HALT_ECALL
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [DATA_W-1:0]             load_data,
    input  logic                          load_last,
    input  logic                          start,
    input  logic [31:0]                   core_inst,
    output logic                          imem_we,
    output logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    output logic [DATA_W-1:0]             imem_wdata,
    output logic                          core_rst,
    output logic                          core_en,
    output logic                          done,
    output logic                          halted,
    output logic                          timed_out,
    output logic [31:0]                   cycle_count
);

    localparam int unsigned AW = $clog2(IMEM_DEPTH);

    run_state_e        state_q, state_d;
    logic              load_ready_q, imem_we_q, core_rst_q, core_en_q;
    logic              done_q, halted_q, timed_out_q;
    logic [AW-1:0]     imem_waddr_q, addr_nxt;
    logic [DATA_W-1:0] imem_wdata_q;
    logic              accept, idle_like, load_end, clr_status;
    logic              hold_load, hold_tc, run_tc;
    logic [31:0]       hold_cnt_unused;

    assign accept     = load_valid && load_ready_q;
    assign idle_like  = (state_q == S_IDLE) || (state_q == S_HALTED) || (state_q == S_TIMEOUT);
    assign addr_nxt   = (state_q == S_LOAD) ? imem_waddr_q + AW'(1) : '0;
    // Top address ends the load as well, so the image never wraps onto word 0.
    assign load_end   = load_last || (&addr_nxt);
    assign clr_status = idle_like && (accept || start);
    assign hold_load  = (state_d == S_RST_HOLD) && (state_q != S_RST_HOLD);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_HALTED, S_TIMEOUT: begin
                if (accept)     state_d = load_end ? S_RST_HOLD : S_LOAD;
                else if (start) state_d = S_RST_HOLD;
            end
            S_LOAD:     if (accept && load_end) state_d = S_RST_HOLD;
            S_RST_HOLD: if (hold_tc) state_d = S_RUN;
            S_RUN: begin
                if (core_inst == HALT_INSTR) state_d = S_HALTED;
                else if (run_tc)             state_d = S_TIMEOUT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    run_timer u_hold_timer (
        .clk        (clk),
        .rst_n      (rst),
        .clr_i      (1'b0),
        .load_i     (hold_load),
        .load_val_i (32'd0),
        .en_i       (state_q == S_RST_HOLD),
        .term_i     (32'(RST_CYCLES)),
        .cnt_o      (hold_cnt_unused),
        .tc_o       (hold_tc)
    );

    run_timer u_run_timer (
        .clk        (clk),
        .rst_n      (rst),
        .clr_i      (clr_status),
        .load_i     (1'b0),
        .load_val_i (32'd0),
        .en_i       (state_q == S_RUN),
        .term_i     (32'(TIMEOUT_CYCLES)),
        .cnt_o      (cycle_count),
        .tc_o       (run_tc)
    );

    // Outputs are derived from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            load_ready_q <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_waddr_q <= '0;
            imem_wdata_q <= '0;
            core_rst_q   <= 1'b1;
            core_en_q    <= 1'b0;
            done_q       <= 1'b0;
            halted_q     <= 1'b0;
            timed_out_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_ready_q <= (state_d != S_RST_HOLD) && (state_d != S_RUN);
            core_rst_q   <= (state_d == S_IDLE) || (state_d == S_LOAD) || (state_d == S_RST_HOLD);
            core_en_q    <= (state_d == S_RUN);
            imem_we_q    <= accept;
            if (accept) begin
                imem_waddr_q <= addr_nxt;
                imem_wdata_q <= load_data;
            end
            if (clr_status) begin
                done_q      <= 1'b0;
                halted_q    <= 1'b0;
                timed_out_q <= 1'b0;
            end else if (state_q == S_RUN && state_d == S_HALTED) begin
                done_q   <= 1'b1;
                halted_q <= 1'b1;
            end else if (state_q == S_RUN && state_d == S_TIMEOUT) begin
                done_q      <= 1'b1;
                timed_out_q <= 1'b1;
            end
        end
    end

    assign load_ready = load_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_waddr = imem_waddr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_rst   = core_rst_q;
    assign core_en    = core_en_q;
    assign done       = done_q;
    assign halted     = halted_q;
    assign timed_out  = timed_out_q;

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Randomized self-checking bench for proc_run_ctrl with a small imem/core model.
module tb_proc_run_ctrl;
    import proc_run_pkg::*;

    localparam int DEPTH = 32;
    localparam int RSTC  = 4;
    localparam int TMO   = 20;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [31:0] HALT = HALT_ECALL;

    logic clk = 1'b0, rst = 1'b0;
    logic load_valid = 1'b0, load_last = 1'b0, start = 1'b0;
    logic [31:0] load_data = '0;
    logic [31:0] core_inst;
    logic load_ready, imem_we, core_rst, core_en, done, halted, timed_out;
    logic [AW-1:0] imem_waddr;
    logic [31:0] imem_wdata, cycle_count;

    int checks = 0, failures = 0;
    logic [31:0] tb_mem  [DEPTH];
    logic [31:0] mdl_mem [DEPTH];
    logic [31:0] prog_q[$];
    int          wa_q[$];
    logic [31:0] wd_q[$];

    proc_run_ctrl #(.DATA_W(32), .IMEM_DEPTH(DEPTH), .RST_CYCLES(RSTC),
                    .TIMEOUT_CYCLES(TMO), .HALT_INSTR(HALT)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_last(load_last), .start(start), .core_inst(core_inst),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .core_rst(core_rst), .core_en(core_en), .done(done), .halted(halted),
        .timed_out(timed_out), .cycle_count(cycle_count));

    always #5 clk = ~clk;

    // Environment: instruction memory plus a core that fetches word cycle_count.
    assign core_inst = core_en ? tb_mem[cycle_count[AW-1:0]] : 32'h0;
    always @(posedge clk) begin
        if (imem_we) begin
            tb_mem[imem_waddr] <= imem_wdata;
            wa_q.push_back(int'(imem_waddr));
            wd_q.push_back(imem_wdata);
        end
    end

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == HALT) w = ~w;
        return w;
    endfunction

    function automatic void mk_prog(input int n, input int hp);
        prog_q.delete();
        for (int i = 0; i < n; i++) prog_q.push_back(rand_word());
        if (hp >= 0 && hp < n) prog_q[hp] = HALT;
    endfunction

    // Outcome of a run from the program image alone.
    function automatic void model_run(output bit h, output int cnt);
        h = 1'b0;
        cnt = TMO;
        for (int k = 0; k < TMO; k++) begin
            if (mdl_mem[k % DEPTH] == HALT) begin
                h = 1'b1;
                cnt = k + 1;
                break;
            end
        end
    endfunction

    task automatic stream(input string nm, input bit use_last, input int gap_max);
        int n, i, acc, exp_acc, t;
        bit v;
        logic lr;
        n = prog_q.size(); i = 0; acc = 0; t = 0;
        wa_q.delete(); wd_q.delete();
        exp_acc = (n < DEPTH) ? n : DEPTH;
        while (i < n && t < 4000) begin
            v = ($urandom_range(0, gap_max) == 0);
            load_valid = v;
            load_data  = prog_q[i];
            load_last  = use_last && (i == n - 1);
            lr = load_ready;
            @(negedge clk); t++;
            if (v && lr) begin
                i++; acc++;
                if (!load_ready) break;
            end
        end
        load_valid = 1'b0; load_last = 1'b0;
        for (int k = 0; k < exp_acc; k++) mdl_mem[k] = prog_q[k];
        checks++;
        if (acc !== exp_acc) begin
            failures++;
            $display("FAIL %s accepted words: got %0d expected %0d", nm, acc, exp_acc);
        end
    endtask

    task automatic check_writes(input string nm, input int exp_n);
        int bad;
        checks++;
        if (wa_q.size() != exp_n) begin
            failures++;
            $display("FAIL %s write count: got %0d expected %0d", nm, wa_q.size(), exp_n);
        end
        bad = -1;
        for (int k = 0; k < wa_q.size() && k < exp_n; k++)
            if (wa_q[k] != k || wd_q[k] !== prog_q[k]) begin bad = k; break; end
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s write %0d: got addr %0d data %h expected addr %0d data %h",
                     nm, bad, wa_q[bad], wd_q[bad], bad, prog_q[bad]);
        end
    endtask

    // Called at the negedge right after the run was launched (RST_HOLD).
    task automatic run_check(input string nm, input bit poke);
        bit eh;
        int ec, hold, runc, t;
        model_run(eh, ec);
        hold = 0; runc = 0; t = 0;
        while (!core_en && t < 100) begin
            if (core_rst && !load_ready) hold++;
            @(negedge clk); t++;
        end
        checks++;
        if (hold !== RSTC) begin
            failures++;
            $display("FAIL %s reset hold cycles: got %0d expected %0d", nm, hold, RSTC);
        end
        while (!done && t < 400) begin
            if (core_en) runc++;
            start = poke && core_en && (runc == 2);
            @(negedge clk); t++;
        end
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || halted !== eh || timed_out !== !eh) begin
            failures++;
            $display("FAIL %s flags: got done=%b halted=%b timed_out=%b expected 1 %b %b",
                     nm, done, halted, timed_out, eh, !eh);
        end
        checks++;
        if (cycle_count !== 32'(ec) || runc !== ec) begin
            failures++;
            $display("FAIL %s cycle_count: got %0d (run cycles %0d) expected %0d", nm, cycle_count, runc, ec);
        end
        checks++;
        if (core_en !== 1'b0 || core_rst !== 1'b0 || load_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s stopped outputs: got core_en=%b core_rst=%b load_ready=%b expected 0 0 1",
                     nm, core_en, core_rst, load_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({core_rst, core_en, imem_we, done, halted, timed_out, load_ready} !== 7'b1000000 ||
            imem_waddr !== '0 || imem_wdata !== '0 || cycle_count !== 32'd0) begin
            failures++;
            $display("FAIL reset values: got rst/en/we/done/h/to/rdy=%b%b%b%b%b%b%b addr=%0d cnt=%0d expected 1000000 0 0",
                     core_rst, core_en, imem_we, done, halted, timed_out, load_ready, imem_waddr, cycle_count);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (load_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset load_ready before clock: got %b expected 0", load_ready);
        end
        @(negedge clk);
        checks++;
        if (load_ready !== 1'b1 || core_rst !== 1'b1) begin
            failures++;
            $display("FAIL idle after reset: got load_ready=%b core_rst=%b expected 1 1", load_ready, core_rst);
        end
    endtask

    task automatic test_basic();
        prog_q = '{32'h0020_0093, 32'h0030_8113, 32'h0000_0073};
        wa_q.delete(); wd_q.delete();
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1; load_data = prog_q[i]; load_last = (i == 2);
            @(negedge clk);
            checks++;
            if (imem_we !== 1'b1 || imem_waddr !== AW'(i) || imem_wdata !== prog_q[i]) begin
                failures++;
                $display("FAIL basic write %0d: got we=%b addr=%0d data=%h expected 1 %0d %h",
                         i, imem_we, imem_waddr, imem_wdata, i, prog_q[i]);
            end
        end
        load_valid = 1'b0; load_last = 1'b0;
        for (int k = 0; k < 3; k++) mdl_mem[k] = prog_q[k];
        run_check("basic", 1'b0);
        checks++;
        if (halted !== 1'b1 || cycle_count !== 32'd3) begin
            failures++;
            $display("FAIL basic halt: got halted=%b count=%0d expected 1 3", halted, cycle_count);
        end
        check_writes("basic", 3);
    endtask

    task automatic test_restart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || halted !== 1'b0 || cycle_count !== 32'd0 || core_rst !== 1'b1 || load_ready !== 1'b0) begin
            failures++;
            $display("FAIL restart clear: got done=%b halted=%b cnt=%0d core_rst=%b rdy=%b expected 0 0 0 1 0",
                     done, halted, cycle_count, core_rst, load_ready);
        end
        run_check("restart", 1'b1);
    endtask

    task automatic test_timeout();
        mk_prog(TMO, -1);
        stream("timeout", 1'b1, 2);
        run_check("timeout", 1'b0);
        checks++;
        if (timed_out !== 1'b1 || halted !== 1'b0 || cycle_count !== 32'(TMO)) begin
            failures++;
            $display("FAIL timeout result: got to=%b h=%b cnt=%0d expected 1 0 %0d", timed_out, halted, cycle_count, TMO);
        end
        check_writes("timeout", TMO);
    endtask

    task automatic test_overflow();
        mk_prog(DEPTH + 2, -1);
        stream("overflow", 1'b0, 1);
        checks++;
        if (load_ready !== 1'b0 || core_rst !== 1'b1 || imem_we !== 1'b1 || imem_waddr !== AW'(DEPTH - 1)) begin
            failures++;
            $display("FAIL overflow stop: got rdy=%b core_rst=%b we=%b addr=%0d expected 0 1 1 %0d",
                     load_ready, core_rst, imem_we, imem_waddr, DEPTH - 1);
        end
        run_check("overflow", 1'b0);
        check_writes("overflow", DEPTH);
    endtask

    task automatic test_halt_vs_timeout();
        mk_prog(TMO, TMO - 1);
        stream("halt_vs_to", 1'b1, 0);
        run_check("halt_vs_to", 1'b0);
        checks++;
        if (halted !== 1'b1 || timed_out !== 1'b0 || cycle_count !== 32'(TMO)) begin
            failures++;
            $display("FAIL halt_vs_to priority: got h=%b to=%b cnt=%0d expected 1 0 %0d", halted, timed_out, cycle_count, TMO);
        end
    endtask

    task automatic test_collision();
        mk_prog(TMO, $urandom_range(1, TMO - 1));
        start = 1'b1; load_valid = 1'b1; load_data = prog_q[0]; load_last = 1'b0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (load_ready !== 1'b1 || done !== 1'b0 || cycle_count !== 32'd0 || imem_we !== 1'b1 || imem_waddr !== '0) begin
            failures++;
            $display("FAIL collision load wins: got rdy=%b done=%b cnt=%0d we=%b addr=%0d expected 1 0 0 1 0",
                     load_ready, done, cycle_count, imem_we, imem_waddr);
        end
        for (int i = 1; i < TMO; i++) begin
            load_data = prog_q[i]; load_last = (i == TMO - 1);
            @(negedge clk);
        end
        load_valid = 1'b0; load_last = 1'b0;
        for (int k = 0; k < TMO; k++) mdl_mem[k] = prog_q[k];
        run_check("collision", 1'b0);
    endtask

    task automatic test_reset_mid_run();
        int t;
        mk_prog(TMO, -1);
        stream("midrun", 1'b1, 0);
        t = 0;
        while (!(core_en && cycle_count == 32'd7) && t < 100) begin @(negedge clk); t++; end
        checks++;
        if (t >= 100) begin
            failures++;
            $display("FAIL midrun reach count 7: got %0d expected 7", cycle_count);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (core_rst !== 1'b1 || core_en !== 1'b0 || cycle_count !== 32'd0 || load_ready !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL midrun async reset: got core_rst=%b en=%b cnt=%0d rdy=%b done=%b expected 1 0 0 0 0",
                     core_rst, core_en, cycle_count, load_ready, done);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_check("midrun rerun", 1'b0);
    endtask

    task automatic test_random();
        int n, hp;
        bit ul;
        for (int it = 0; it < 6; it++) begin
            n  = $urandom_range(1, DEPTH + 2);
            hp = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, TMO + 4);
            ul = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
            mk_prog(n, hp);
            stream("random", ul, 2);
            run_check("random", 1'($urandom_range(0, 1)));
            check_writes("random", (n < DEPTH) ? n : DEPTH);
        end
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) mdl_mem[k] = 32'h0;
        test_reset();
        test_basic();
        test_restart();
        test_timeout();
        test_overflow();
        test_halt_vs_timeout();
        test_collision();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
